// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared button indices and per-channel state encoding
package nes_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        RELEASED,
        PRESS_PEND,
        HELD,
        REPEATING,
        RELEASE_PEND
    } btn_state_t;

endpackage

// File: rtl/nes_button_channel.sv
// rtl/nes_button_channel.sv - frame-based debounce and auto-repeat FSM for one button
module nes_button_channel
    import nes_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_PERIOD   = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic sample_valid,
    input  logic sample,
    output logic held,
    output logic held_next,
    output logic pressed,
    output logic released,
    output logic repeat_pulse
);

    localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_FRAMES);
    localparam logic [5:0] DELAY_THR = 6'(REPEAT_DELAY);
    localparam logic [5:0] PERIOD_THR = 6'(REPEAT_PERIOD);

    btn_state_t  state;
    logic [3:0]  deb;
    logic [5:0]  hold;
    logic        rep;
    logic [3:0]  deb_inc;
    logic [5:0]  hold_inc;
    logic [5:0]  hold_thr;

    assign deb_inc  = deb + 4'd1;
    assign hold_inc = hold + 6'd1;
    assign hold_thr = (state == HELD) ? DELAY_THR : PERIOD_THR;

    // Next debounced level, exported so the top can register any_held on the same edge
    always_comb begin
        held_next = held;
        if (sample_valid) begin
            case (state)
                RELEASED:     held_next = sample && (DEBOUNCE_FRAMES == 1);
                PRESS_PEND:   held_next = sample && (deb_inc == DEB_LAST);
                HELD,
                REPEATING:    held_next = sample || (DEBOUNCE_FRAMES != 1);
                RELEASE_PEND: held_next = sample || (deb_inc != DEB_LAST);
                default:      held_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= RELEASED;
            deb          <= 4'd0;
            hold         <= 6'd0;
            rep          <= 1'b0;
            held         <= 1'b0;
            pressed      <= 1'b0;
            released     <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            pressed      <= 1'b0;
            released     <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= held_next;
            if (sample_valid) begin
                case (state)
                    RELEASED: begin
                        if (sample) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                state   <= HELD;
                                pressed <= 1'b1;
                                hold    <= 6'd0;
                                rep     <= 1'b0;
                            end else begin
                                state <= PRESS_PEND;
                                deb   <= 4'd1;
                            end
                        end
                    end
                    PRESS_PEND: begin
                        if (!sample) begin
                            state <= RELEASED;
                            deb   <= 4'd0;
                        end else if (deb_inc == DEB_LAST) begin
                            state   <= HELD;
                            pressed <= 1'b1;
                            deb     <= 4'd0;
                            hold    <= 6'd0;
                            rep     <= 1'b0;
                        end else begin
                            deb <= deb_inc;
                        end
                    end
                    HELD, REPEATING: begin
                        if (!sample) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                state    <= RELEASED;
                                released <= 1'b1;
                                hold     <= 6'd0;
                                rep      <= 1'b0;
                            end else begin
                                state <= RELEASE_PEND;
                                deb   <= 4'd1;
                            end
                        end else if (REPEAT_DELAY != 0) begin
                            // With repeat disabled the hold counter parks at zero
                            if (hold_inc == hold_thr) begin
                                state        <= REPEATING;
                                repeat_pulse <= 1'b1;
                                hold         <= 6'd0;
                                rep          <= 1'b1;
                            end else begin
                                hold <= hold_inc;
                            end
                        end
                    end
                    RELEASE_PEND: begin
                        if (sample) begin
                            state <= rep ? REPEATING : HELD;
                            deb   <= 4'd0;
                        end else if (deb_inc == DEB_LAST) begin
                            state    <= RELEASED;
                            released <= 1'b1;
                            deb      <= 4'd0;
                            hold     <= 6'd0;
                            rep      <= 1'b0;
                        end else begin
                            deb <= deb_inc;
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        deb   <= 4'd0;
                        hold  <= 6'd0;
                        rep   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/nes_button_conditioner.sv
// rtl/nes_button_conditioner.sv - debounced levels, edge and auto-repeat pulses for NES buttons
module nes_button_conditioner
    import nes_pkg::*;
#(
    parameter int NUM_BUTTONS     = 8,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_PERIOD   = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sample_valid,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_BUTTONS-1:0] held,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] released,
    output logic [NUM_BUTTONS-1:0] repeat_pulse,
    output logic                   any_held
);

    logic [NUM_BUTTONS-1:0] held_next;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        nes_button_channel #(
            .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clock        (clock),
            .reset        (reset),
            .sample_valid (sample_valid),
            .sample       (buttons[i]),
            .held         (held[i]),
            .held_next    (held_next[i]),
            .pressed      (pressed[i]),
            .released     (released[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            any_held <= 1'b0;
        end else begin
            any_held <= |held_next;
        end
    end

endmodule

// File: tb/tb_nes_button_conditioner.sv
// tb/tb_nes_button_conditioner.sv - directed self-checking bench for nes_button_conditioner
module tb_nes_button_conditioner;
    import nes_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] buttons = 8'h00;
    logic [7:0] held, pressed, released, repeat_pulse;
    logic       any_held;
    logic [7:0] held1, pressed1, released1, repeat1;
    logic       any_held1;
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    nes_button_conditioner dut (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .buttons(buttons),
        .held(held), .pressed(pressed), .released(released),
        .repeat_pulse(repeat_pulse), .any_held(any_held)
    );

    nes_button_conditioner #(.DEBOUNCE_FRAMES(1), .REPEAT_DELAY(0)) dut1 (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .buttons(buttons),
        .held(held1), .pressed(pressed1), .released(released1),
        .repeat_pulse(repeat1), .any_held(any_held1)
    );

    task automatic strobe(input logic [7:0] b);
        @(negedge clock);
        buttons      = b;
        sample_valid = 1'b1;
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({held, pressed, released, repeat_pulse, any_held} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {held, pressed, released, repeat_pulse, any_held});
        end
        checks++;
        if ({held1, pressed1, released1, repeat1, any_held1} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs_df1: got %h required 0", {held1, pressed1, released1, repeat1, any_held1});
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        logic [7:0] up;
        up = 8'h01 << BTN_UP;
        do_reset();
        for (int f = 1; f <= 35; f++) strobe(up);
        checks++;
        if (held !== up || any_held !== 1'b1) begin
            errors++;
            $display("FAIL midhold_held: got held=%h any=%b required held=%h any=1", held, any_held, up);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({held, pressed, released, repeat_pulse, any_held} !== 33'd0) begin
            errors++;
            $display("FAIL midhold_async_reset: got %h required 0", {held, pressed, released, repeat_pulse, any_held});
        end
        @(negedge clock);
        reset = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            strobe(up);
            checks++;
            if (pressed !== ((f == 3) ? up : 8'h00) || held !== ((f == 3) ? up : 8'h00)) begin
                errors++;
                $display("FAIL midhold_repress f%0d: got pressed=%h held=%h", f, pressed, held);
            end
        end
    endtask

    task automatic test_glitch_reject();
        logic [5:0] pat;
        logic [7:0] exp_p;
        pat = 6'b111011;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            strobe({7'd0, pat[f]});
            exp_p = (f == 5) ? 8'h01 : 8'h00;
            checks++;
            if (pressed !== exp_p || held !== exp_p || released !== 8'h00) begin
                errors++;
                $display("FAIL glitch_s%0d: got pressed=%h held=%h rel=%h required pressed=%h", f + 1, pressed, held, released, exp_p);
            end
        end
        idle_cycle();
        checks++;
        if (pressed !== 8'h00 || held !== 8'h01) begin
            errors++;
            $display("FAIL glitch_pulse_width: got pressed=%h held=%h required 00/01", pressed, held);
        end
    endtask

    task automatic test_strobe_gating();
        int bad;
        bad = 0;
        do_reset();
        @(negedge clock);
        buttons = 8'hFF;
        sample_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            idle_cycle();
            if ({held, pressed, released, repeat_pulse, any_held} !== 33'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL strobe_gating: %0d cycles with nonzero outputs, required 0", bad);
        end
    endtask

    task automatic test_auto_repeat();
        logic [7:0] r, ep, er, eh;
        r = 8'h01 << BTN_RIGHT;
        do_reset();
        for (int f = 1; f <= 50; f++) begin
            strobe(r);
            ep = (f == 3) ? r : 8'h00;
            er = (f == 33 || f == 39 || f == 45) ? r : 8'h00;
            eh = (f >= 3) ? r : 8'h00;
            checks++;
            if (pressed !== ep || repeat_pulse !== er || held !== eh || released !== 8'h00) begin
                errors++;
                $display("FAIL repeat_f%0d: got p=%h rep=%h h=%h rel=%h required p=%h rep=%h h=%h rel=00",
                         f, pressed, repeat_pulse, held, released, ep, er, eh);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [5:0] pat;
        logic [7:0] b, eh, erl;
        int         rep_frame;
        b   = 8'h01 << BTN_B;
        pat = 6'b000100;
        do_reset();
        for (int f = 1; f <= 5; f++) strobe(b);
        for (int f = 0; f < 6; f++) begin
            strobe(pat[f] ? b : 8'h00);
            eh  = (f == 5) ? 8'h00 : b;
            erl = (f == 5) ? b : 8'h00;
            checks++;
            if (held !== eh || released !== erl || pressed !== 8'h00) begin
                errors++;
                $display("FAIL bounce_s%0d: got h=%h rel=%h p=%h required h=%h rel=%h", f + 1, held, released, pressed, eh, erl);
            end
        end
        // Repeat timing: press (hold=0), 20 held frames, bounce 0,0,1, then the 10th frame repeats
        do_reset();
        for (int f = 1; f <= 23; f++) strobe(b);
        strobe(8'h00);
        strobe(8'h00);
        strobe(b);
        rep_frame = 0;
        for (int f = 1; f <= 12; f++) begin
            strobe(b);
            if (repeat_pulse === b && rep_frame == 0) rep_frame = f;
        end
        checks++;
        if (rep_frame != 10) begin
            errors++;
            $display("FAIL bounce_repeat_timing: got first repeat at frame %0d required 10", rep_frame);
        end
    endtask

    task automatic test_simultaneous();
        int rep_seen;
        rep_seen = 0;
        do_reset();
        strobe(8'h00);
        checks++;
        if ({held1, pressed1, released1, repeat1, any_held1} !== 33'd0) begin
            errors++;
            $display("FAIL simul_idle: got %h required 0", {held1, pressed1, released1, repeat1, any_held1});
        end
        strobe(8'h81);
        checks++;
        if (pressed1 !== 8'h81 || held1 !== 8'h81 || any_held1 !== 1'b1 || released1 !== 8'h00) begin
            errors++;
            $display("FAIL simul_press: got p=%h h=%h any=%b required p=81 h=81 any=1", pressed1, held1, any_held1);
        end
        for (int f = 0; f < 70; f++) begin
            strobe(8'h81);
            if (repeat1 !== 8'h00 || pressed1 !== 8'h00) rep_seen++;
        end
        strobe(8'h00);
        if (repeat1 !== 8'h00) rep_seen++;
        checks++;
        if (released1 !== 8'h81 || held1 !== 8'h00 || any_held1 !== 1'b0 || pressed1 !== 8'h00) begin
            errors++;
            $display("FAIL simul_release: got rel=%h h=%h any=%b required rel=81 h=00 any=0", released1, held1, any_held1);
        end
        checks++;
        if (rep_seen != 0) begin
            errors++;
            $display("FAIL simul_no_repeat: got %0d stray pulses required 0", rep_seen);
        end
        idle_cycle();
        checks++;
        if (released1 !== 8'h00) begin
            errors++;
            $display("FAIL simul_release_width: got rel=%h required 00", released1);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_hold();
        test_glitch_reject();
        test_strobe_gating();
        test_auto_repeat();
        test_release_bounce();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
